ddr2_dqs_wr_gen: RTL

Write-strobe sequencer for the DDR2 controller's data path. It drives the `A` and `TS` inputs of the differential SSTL18 DQS pad, so the pad puts a DDR2-compliant strobe on the bus. Each write burst gets a preamble, a toggling phase of 4 or 8 beats, and a postamble, after which the bus is released to high-Z. It also produces the matching DQ output-enable window, and back-to-back bursts chain without a gap.

---
 rtl/ddr2_dqs_wr_gen_if.sv | 22 ++
 rtl/ddr2_dqs_wr_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ddr2_dqs_wr_gen_if.sv
// Handshake and pad-drive bundle between the write data path and the DQS strobe sequencer.
// The sequencer is the slave; the requester (controller or bench) is the master.
interface ddr2_dqs_wr_gen_if;
  logic       wr_start;
  logic       bl8;
  logic       wr_ready;
  logic       dqs_a;
  logic       dqs_ts;
  logic       dq_oe;
  logic [2:0] beat_idx;
  logic       burst_done;

  modport master (
    output wr_start, bl8,
    input  wr_ready, dqs_a, dqs_ts, dq_oe, beat_idx, burst_done
  );

  modport slave (
    input  wr_start, bl8,
    output wr_ready, dqs_a, dqs_ts, dq_oe, beat_idx, burst_done
  );
endinterface

// File: rtl/ddr2_dqs_wr_gen.sv
// DDR2 write-strobe sequencer: preamble, 4/8 toggle beats, postamble, then high-Z.
// Drives the DQS pad A/TS inputs and the matching DQ output-enable window.
module ddr2_dqs_wr_gen #(
  parameter int PRE_CYC  = 2,
  parameter int POST_CYC = 1
) (
  input  logic               clk,
  input  logic               reset,
  ddr2_dqs_wr_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRE    = 2'd1,
    TOGGLE = 2'd2,
    POST   = 2'd3
  } state_t;

  localparam logic [3:0] PRE_LOAD  = 4'(PRE_CYC - 1);
  localparam logic [3:0] POST_LOAD = 4'(POST_CYC - 1);
  localparam logic [3:0] BL8_LAST  = 4'd7;
  localparam logic [3:0] BL4_LAST  = 4'd3;

  if (PRE_CYC < 1 || PRE_CYC > 15) begin : g_bad_pre
    $error("PRE_CYC must be in 1..15");
  end
  if (POST_CYC < 1 || POST_CYC > 15) begin : g_bad_post
    $error("POST_CYC must be in 1..15");
  end

  state_t     state;
  logic [3:0] cnt;
  logic       bl_r;
  logic [2:0] beat_q;
  logic       dqs_a_q;
  logic       dqs_ts_q;
  logic       dq_oe_q;
  logic       done_q;

  // In TOGGLE, cnt counts remaining beats, so cnt==0 marks the last beat.
  assign bus.wr_ready   = (state == IDLE) | ((state == TOGGLE) & (cnt == 4'd0));
  assign bus.dqs_a      = dqs_a_q;
  assign bus.dqs_ts     = dqs_ts_q;
  assign bus.dq_oe      = dq_oe_q;
  assign bus.beat_idx   = beat_q;
  assign bus.burst_done = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  // NOTE: the reset is asynchronous so the pad drops TS without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bl_r     <= 1'b0;
      beat_q   <= '0;
      dqs_a_q  <= 1'b0;
      dqs_ts_q <= 1'b0;
      dq_oe_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_start) begin
            state    <= PRE;
            bl_r     <= bus.bl8;
            cnt      <= PRE_LOAD;
            dqs_ts_q <= 1'b1;
            dqs_a_q  <= 1'b0;
          end
        end

        PRE: begin
          if (cnt == 4'd0) begin
            state   <= TOGGLE;
            cnt     <= bl_r ? BL8_LAST : BL4_LAST;
            beat_q  <= '0;
            dqs_a_q <= 1'b1;
            dq_oe_q <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        TOGGLE: begin
          if (cnt == 4'd0) begin
            if (bus.wr_start) begin
              // Gapless chain: next burst starts toggling on the very next beat.
              bl_r    <= bus.bl8;
              cnt     <= bus.bl8 ? BL8_LAST : BL4_LAST;
              beat_q  <= '0;
              dqs_a_q <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state   <= POST;
              cnt     <= POST_LOAD;
              beat_q  <= '0;
              dqs_a_q <= 1'b0;
              dq_oe_q <= 1'b0;
              done_q  <= 1'b0;
            end
          end else begin
            cnt     <= cnt - 4'd1;
            beat_q  <= beat_q + 3'd1;
            dqs_a_q <= ~dqs_a_q;
            done_q  <= (cnt == 4'd1);
          end
        end

        POST: begin
          if (cnt == 4'd0) begin
            state    <= IDLE;
            dqs_ts_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
